// File: rtl/i2c_pkg.sv
// Shared command bits, FSM state encoding and per-step command/byte encoding
// for the I2C register transaction sequencer.
package i2c_pkg;

  localparam logic [5:0] CMD_WR   = 6'b000001;
  localparam logic [5:0] CMD_STA  = 6'b000010;
  localparam logic [5:0] CMD_RD   = 6'b000100;
  localparam logic [5:0] CMD_STO  = 6'b001000;
  localparam logic [5:0] CMD_ACK  = 6'b010000;
  localparam logic [5:0] CMD_NACK = 6'b100000;

  localparam logic [5:0] CMD_ADDR    = CMD_STA | CMD_WR;
  localparam logic [5:0] CMD_BYTE    = CMD_WR;
  localparam logic [5:0] CMD_WR_LAST = CMD_WR | CMD_STO;
  localparam logic [5:0] CMD_RD_LAST = CMD_RD | CMD_NACK | CMD_STO;

  typedef enum logic [3:0] {
    IDLE, W_DEV, W_REG, W_DAT, R_DEVW, R_REG, R_DEVR, R_DAT, ABORT, DONE
  } state_t;

  typedef enum logic {PH_ISSUE, PH_WAIT} phase_t;

  typedef struct packed {
    logic [5:0] cmd;
    logic [7:0] tx;
  } step_t;

  function automatic step_t step_enc(state_t s, logic [6:0] dev, logic [7:0] ra,
                                     logic [7:0] wd);
    case (s)
      W_DEV, R_DEVW: return '{cmd: CMD_ADDR,    tx: {dev, 1'b0}};
      W_REG, R_REG:  return '{cmd: CMD_BYTE,    tx: ra};
      W_DAT:         return '{cmd: CMD_WR_LAST, tx: wd};
      R_DEVR:        return '{cmd: CMD_ADDR,    tx: {dev, 1'b1}};
      default:       return '{cmd: CMD_RD_LAST, tx: 8'h00};
    endcase
  endfunction

  function automatic state_t next_step(state_t s);
    case (s)
      W_DEV:   return W_REG;
      W_REG:   return W_DAT;
      R_DEVW:  return R_REG;
      R_REG:   return R_DEVR;
      R_DEVR:  return R_DAT;
      default: return DONE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_wdt.sv
// Per-step watchdog: cleared when a step is issued, counts while waiting for
// trans_done and flags expiry at LIMIT-1. Only used in I2C_WDT_EN builds.
module i2c_wdt #(
  parameter int unsigned LIMIT = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [31:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign expired = en && (cnt == LIMIT - 1);

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Single-byte I2C register read/write sequencer driving the bit-level shifter.
// Define I2C_WDT_EN to abort a step that gets no trans_done within WDT_CYCLES.
module i2c_reg_ctrl #(
  parameter int unsigned WDT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       rw_done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic [5:0] cmd,
  output logic       go,
  output logic [7:0] tx_data,
  input  logic       trans_done,
  input  logic [7:0] rx_data,
  input  logic       ack_o
);
  import i2c_pkg::*;

  state_t     state;
  phase_t     phase;
  logic [6:0] dev_q;
  logic [7:0] reg_q;
  logic [7:0] wdat_q;
  step_t      step;
  logic       accept;
  logic       wdt_expired;

  assign accept = (state == IDLE) && !busy && (wr_req || rd_req);
  assign step   = step_enc(state, dev_q, reg_q, wdat_q);

  // Request operands are data only: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      dev_q  <= dev_addr;
      reg_q  <= reg_addr;
      wdat_q <= wr_data;
    end
  end

`ifdef I2C_WDT_EN
  logic wdt_clr;
  logic wdt_en;

  assign wdt_clr = (phase == PH_ISSUE) && (state != IDLE) && (state != DONE);
  assign wdt_en  = (phase == PH_WAIT);

  i2c_wdt #(.LIMIT(WDT_CYCLES)) u_wdt (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdt_clr),
    .en      (wdt_en),
    .expired (wdt_expired)
  );
`else
  logic unused_wdt_cfg;

  assign unused_wdt_cfg = ^WDT_CYCLES;
  assign wdt_expired    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= PH_ISSUE;
      busy    <= 1'b0;
      rw_done <= 1'b0;
      ack_err <= 1'b0;
      rd_data <= 8'h00;
      cmd     <= 6'h00;
      go      <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      go      <= 1'b0;
      rw_done <= 1'b0;
      case (state)
        IDLE: begin
          // busy is still high during the rw_done cycle and drops here.
          if (accept) begin
            state   <= wr_req ? W_DEV : R_DEVW;
            phase   <= PH_ISSUE;
            busy    <= 1'b1;
            ack_err <= 1'b0;
          end else begin
            busy <= 1'b0;
          end
        end
        DONE: begin
          rw_done <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          if (phase == PH_ISSUE) begin
            go      <= 1'b1;
            cmd     <= step.cmd;
            tx_data <= step.tx;
            phase   <= PH_WAIT;
          end else if (trans_done) begin
            phase <= PH_ISSUE;
            if (state == R_DAT) begin
              rd_data <= rx_data;
              state   <= DONE;
            end else if (state == ABORT) begin
              state <= DONE;
            end else if (ack_o) begin
              // A NACK on a step that already sent STOP needs no bus release.
              ack_err <= 1'b1;
              state   <= (state == W_DAT) ? DONE : ABORT;
            end else begin
              state <= next_step(state);
            end
          end else if (wdt_expired) begin
            ack_err <= 1'b1;
            rw_done <= 1'b1;
            phase   <= PH_ISSUE;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Randomized + directed bench for i2c_reg_ctrl with a reactive shifter model
// and a transaction-level reference of the expected command sequence.
module tb_i2c_reg_ctrl;

  localparam int unsigned WDT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_req = 1'b0, rd_req = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0, wr_data = '0;
  logic       busy, rw_done, ack_err, go;
  logic [7:0] rd_data, tx_data;
  logic [5:0] cmd;
  logic       trans_done = 1'b0, ack_o = 1'b0;
  logic [7:0] rx_data = '0;

  i2c_reg_ctrl #(.WDT_CYCLES(WDT)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .dev_addr   (dev_addr),
    .reg_addr   (reg_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .rw_done    (rw_done),
    .ack_err    (ack_err),
    .rd_data    (rd_data),
    .cmd        (cmd),
    .go         (go),
    .tx_data    (tx_data),
    .trans_done (trans_done),
    .rx_data    (rx_data),
    .ack_o      (ack_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  // Shifter model: logs each go, answers after a random delay.
  logic [13:0] go_log[$];
  int          nack_step = -1;
  int          hang_from = 99;
  int          step_idx  = 0;
  int          dly       = 0;
  bit          pend      = 0;
  logic [7:0]  rx_val    = '0;

  always @(negedge clk) begin
    trans_done = 1'b0;
    ack_o      = 1'b0;
    rx_data    = 8'($urandom);
    if (rst || !busy) begin
      pend     = 0;
      step_idx = 0;
      if (!rst && $urandom_range(0, 5) == 0) begin
        trans_done = 1'b1;
        ack_o      = 1'b1;
      end
    end else if (go) begin
      go_log.push_back({cmd, tx_data});
      pend = 1;
      dly  = $urandom_range(0, 3);
    end else if (pend && step_idx < hang_from) begin
      if (dly == 0) begin
        trans_done = 1'b1;
        ack_o      = (step_idx == nack_step) || (step_idx == 3);
        if (step_idx == 3) rx_data = rx_val;
        pend = 0;
        step_idx++;
      end else begin
        dly--;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expected go sequence, error flag and read-back register.
  logic [13:0] exp_q[$];
  logic        exp_err;
  logic [7:0]  rd_ref = 8'h00;

  task automatic build_exp(bit wr, logic [6:0] d, logic [7:0] r, logic [7:0] w,
                           int nk, logic [7:0] rx);
    logic [13:0] seq[$];
    seq.delete();
    exp_q.delete();
    seq.push_back({6'h03, d, 1'b0});
    seq.push_back({6'h01, r});
    if (wr) begin
      seq.push_back({6'h09, w});
    end else begin
      seq.push_back({6'h03, d, 1'b1});
      seq.push_back({6'h2C, 8'h00});
    end
    exp_err = (nk >= 0) && (nk <= 2);
    for (int i = 0; i < seq.size(); i++) begin
      exp_q.push_back(seq[i]);
      if (exp_err && i == nk) begin
        if (!(wr && i == 2)) exp_q.push_back({6'h2C, 8'h00});
        break;
      end
    end
    if (!wr && !exp_err) rd_ref = rx;
  endtask

  task automatic txn(string tag, bit wr, bit rd, logic [6:0] d, logic [7:0] r,
                     logic [7:0] w, int nk, logic [7:0] rx, bit poke_rd);
    bit          seen;
    logic [13:0] obs;
    int          n_go;
    build_exp(wr, d, r, w, nk, rx);
    nack_step = nk;
    rx_val    = rx;
    hang_from = 99;
    go_log.delete();
    @(negedge clk);
    wr_req = wr; rd_req = rd; dev_addr = d; reg_addr = r; wr_data = w;
    @(negedge clk);
    wr_req = 0; rd_req = 0;
    dev_addr = 7'($urandom); reg_addr = 8'($urandom); wr_data = 8'($urandom);
    chk({tag, " busy_on_accept"}, 32'(busy), 32'd1);
    chk({tag, " go_not_yet"}, 32'(go), 32'd0);
    @(negedge clk);
    chk({tag, " go_first"}, 32'(go), 32'd1);
    chk({tag, " cmd_first"}, 32'(cmd), 32'h03);
    seen = 0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      rd_req = poke_rd && (t == 1);
      if (rw_done) seen = 1;
    end
    rd_req = 0;
    chk({tag, " rw_done_seen"}, 32'(seen), 32'd1);
    chk({tag, " ack_err"}, 32'(ack_err), 32'(exp_err));
    chk({tag, " rd_data"}, 32'(rd_data), 32'(rd_ref));
    chk({tag, " busy_at_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " rw_done_pulse"}, 32'(rw_done), 32'd0);
    chk({tag, " go_count"}, 32'(go_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < go_log.size()) ? go_log[i] : 14'hxxxx;
      chk($sformatf("%s step%0d", tag, i), 32'(obs), 32'(exp_q[i]));
    end
    n_go = go_log.size();
    repeat (4) @(negedge clk);
    chk({tag, " no_extra_txn"}, 32'(busy || (go_log.size() != n_go)), 32'd0);
  endtask

  initial begin
    bit seen;
    int t_go;
    int t_done;

    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rw_done", 32'(rw_done), 32'd0);
    chk("reset ack_err", 32'(ack_err), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'h00);
    chk("reset cmd", 32'(cmd), 32'h00);
    chk("reset go", 32'(go), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'h00);
    rst = 0;
    repeat (2) @(negedge clk);

    txn("wr_basic", 1, 0, 7'h32, 8'h10, 8'h5A, -1, 8'h00, 0);
    txn("rd_basic", 0, 1, 7'h32, 8'h00, 8'h00, -1, 8'hA7, 0);
    txn("rd_nack_addr", 0, 1, 7'h32, 8'h05, 8'h00, 0, 8'h3C, 0);
    txn("wr_nack_data", 1, 0, 7'h51, 8'h22, 8'h99, 2, 8'h00, 0);
    txn("rd_nack_rstart", 0, 1, 7'h11, 8'h44, 8'h00, 2, 8'hEE, 0);
    txn("wr_rd_same", 1, 1, 7'h32, 8'h10, 8'h5A, -1, 8'h00, 1);

    for (int k = 0; k < 12; k++) begin
      bit wr;
      int nk;
      wr = 1'($urandom_range(0, 1));
      nk = ($urandom_range(0, 1) == 1) ? -1 : int'($urandom_range(0, 2));
      txn($sformatf("rand%0d", k), wr, !wr, 7'($urandom), 8'($urandom), 8'($urandom),
          nk, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset while the register-address step of a read is waiting.
    nack_step = -1;
    hang_from = 1;
    go_log.delete();
    @(negedge clk);
    rd_req = 1; dev_addr = 7'h32; reg_addr = 8'h00;
    @(negedge clk);
    rd_req = 0;
    for (int t = 0; t < 100 && go_log.size() < 2; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mid cmd_reg_step", 32'(cmd), 32'h01);
    chk("mid busy", 32'(busy), 32'd1);
    #2 rst = 1;
    #1;
    chk("mid_rst busy", 32'(busy), 32'd0);
    chk("mid_rst cmd", 32'(cmd), 32'h00);
    chk("mid_rst tx_data", 32'(tx_data), 32'h00);
    chk("mid_rst rd_data", 32'(rd_data), 32'h00);
    chk("mid_rst ack_err", 32'(ack_err), 32'd0);
    chk("mid_rst go", 32'(go), 32'd0);
    chk("mid_rst rw_done", 32'(rw_done), 32'd0);
    @(negedge clk);
    rst = 0;
    rd_ref = 8'h00;
    hang_from = 99;
    @(negedge clk);
    txn("wr_after_rst", 1, 0, 7'h32, 8'h10, 8'h5A, -1, 8'h00, 0);

    // Shifter never answers.
    hang_from = 0;
    nack_step = -1;
    go_log.delete();
    @(negedge clk);
    wr_req = 1; dev_addr = 7'h32; reg_addr = 8'h10; wr_data = 8'h5A;
    @(negedge clk);
    wr_req = 0;
    seen = 0;
    t_go = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (go) begin seen = 1; t_go = cyc; end
    end
    chk("hang go_seen", 32'(seen), 32'd1);
`ifdef I2C_WDT_EN
    seen = 0;
    t_done = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (rw_done) begin seen = 1; t_done = cyc; end
    end
    chk("wdt rw_done_seen", 32'(seen), 32'd1);
    chk("wdt latency", 32'(t_done - t_go), 32'(WDT));
    chk("wdt ack_err", 32'(ack_err), 32'd1);
    chk("wdt rd_data", 32'(rd_data), 32'(rd_ref));
    @(negedge clk);
    chk("wdt busy_after", 32'(busy), 32'd0);
`else
    seen = 0;
    t_done = 0;
    for (int t = 0; t < 10000; t++) begin
      @(negedge clk);
      if (rw_done) seen = 1;
    end
    chk("nowdt no_rw_done", 32'(seen), 32'd0);
    chk("nowdt still_busy", 32'(busy), 32'd1);
    chk("nowdt single_go", 32'(go_log.size()), 32'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
`endif
    hang_from = 99;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
